// File: rtl/rle_decode_row.sv
// Row run-length decoder: expands packed (run,level) symbols into 8x8 blocks
// of coefficients and emits them one 64-bit raster row at a time.
module rle_decode_row #(
   parameter int DW   = 8,
   parameter int RW   = 4,
   parameter int NSYM = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NSYM*(RW+DW)-1:0]   in_word,
   input  logic [$clog2(NSYM+1)-1:0] in_count,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [8*DW-1:0]           out_row,
   output logic [2:0]                out_row_idx,
   output logic                      out_blk_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      err
);

   localparam int SW = RW + DW;
   localparam int WW = NSYM * SW;
   localparam int CW = $clog2(NSYM + 1);
   localparam int PW = $clog2(NSYM);

   typedef enum logic [1:0] {S_IDLE, S_ZERO, S_LEVEL, S_FILL} state_t;

   state_t                r_state, w_state_next;
   logic [WW-1:0]         r_word;
   logic [CW-1:0]         r_count;
   logic [PW-1:0]         r_sym, w_sym_next;
   logic [RW-1:0]         r_run, w_run_next;
   logic [5:0]            r_idx, w_idx_next;
   logic                  r_full, w_full_next;
   logic                  r_err, w_err_next;
   logic [7:0][DW-1:0]    r_asm;
   logic [8*DW-1:0]       r_out_row;
   logic [2:0]            r_out_row_idx;
   logic                  r_out_blk_last;
   logic                  r_out_valid;

   logic [SW-1:0]         w_syms [NSYM];
   logic [SW-1:0]         w_in_sym0;
   logic [SW-1:0]         w_cur_sym;
   logic [SW-1:0]         w_load_sym;
   logic                  w_load;
   logic                  w_adv;
   logic                  w_capture;
   logic                  w_write;
   logic                  w_row_done;
   logic                  w_stall;
   logic                  w_step;
   logic                  w_last;
   logic [DW-1:0]         w_coef;

   // Unpack the buffered word; symbol 0 sits in the top bits.
   genvar gi;
   generate
      for (gi = 0; gi < NSYM; gi++) begin : g_unpack
         assign w_syms[gi] = r_word[WW-1-gi*SW -: SW];
      end
   endgenerate

   assign w_in_sym0  = in_word[WW-1 -: SW];
   assign w_cur_sym  = w_syms[r_sym];
   assign w_last     = (CW'(r_sym) + CW'(1)) == r_count;
   assign w_capture  = in_valid && !r_full && (in_count != '0);
   assign w_write    = (r_state != S_IDLE);
   assign w_row_done = w_write && (r_idx[2:0] == 3'd7);
   // A completing row may only proceed if the output register is free or being emptied now.
   assign w_stall    = w_row_done && r_out_valid && !out_ready;
   assign w_step     = w_write && !w_stall;
   assign w_coef     = (r_state == S_LEVEL) ? w_cur_sym[DW-1:0] : '0;

   // Next-state logic: symbol sequencing, coefficient index and overrun detection.
   always_comb begin
      w_state_next = r_state;
      w_sym_next   = r_sym;
      w_run_next   = r_run;
      w_idx_next   = r_idx;
      w_full_next  = r_full;
      w_err_next   = r_err;
      w_load       = 1'b0;
      w_load_sym   = '0;
      w_adv        = 1'b0;
      if (!r_full) begin
         // A zero-count word is consumed without ever occupying the buffer.
         if (w_capture) begin
            w_full_next = 1'b1;
            w_sym_next  = '0;
            w_load      = 1'b1;
            w_load_sym  = w_in_sym0;
         end
      end else if (w_step) begin
         w_idx_next = r_idx + 6'd1;
         case (r_state)
            S_ZERO: begin
               if (r_idx == 6'd63) begin
                  // Symbol still has coefficients left past the block end: drop them.
                  w_err_next = 1'b1;
                  w_adv      = 1'b1;
               end else if (r_run == RW'(1)) begin
                  w_state_next = S_LEVEL;
               end else begin
                  w_run_next = r_run - RW'(1);
               end
            end
            S_LEVEL: w_adv = 1'b1;
            S_FILL:  w_adv = (r_idx == 6'd63);
            default: w_adv = 1'b0;
         endcase
         if (w_adv) begin
            if (w_last) begin
               w_state_next = S_IDLE;
               w_full_next  = 1'b0;
            end else begin
               w_sym_next = r_sym + PW'(1);
               w_load     = 1'b1;
               w_load_sym = w_syms[r_sym + PW'(1)];
            end
         end
      end
      if (w_load) begin
         if (w_load_sym == '0) begin
            w_state_next = S_FILL;
         end else if (w_load_sym[SW-1:DW] != '0) begin
            w_state_next = S_ZERO;
            w_run_next   = w_load_sym[SW-1:DW];
         end else begin
            w_state_next = S_LEVEL;
         end
      end
   end

   // State, word buffer, row assembly and output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_word         <= '0;
         r_count        <= '0;
         r_sym          <= '0;
         r_run          <= '0;
         r_idx          <= '0;
         r_full         <= 1'b0;
         r_err          <= 1'b0;
         r_asm          <= '0;
         r_out_row      <= '0;
         r_out_row_idx  <= '0;
         r_out_blk_last <= 1'b0;
         r_out_valid    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_sym   <= w_sym_next;
         r_run   <= w_run_next;
         r_idx   <= w_idx_next;
         r_full  <= w_full_next;
         r_err   <= w_err_next;
         if (w_capture) begin
            r_word  <= in_word;
            r_count <= in_count;
         end
         if (w_step) begin
            if (w_row_done) begin
               r_asm <= '0;
            end else begin
               r_asm[3'd7 - r_idx[2:0]] <= w_coef;
            end
         end
         if (w_step && w_row_done) begin
            // Column 7 is the last coefficient, so it lands in the lowest byte.
            r_out_row      <= {r_asm[7:1], w_coef};
            r_out_row_idx  <= r_idx[5:3];
            r_out_blk_last <= &r_idx[5:3];
            r_out_valid    <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready     = !r_full;
   assign out_row      = r_out_row;
   assign out_row_idx  = r_out_row_idx;
   assign out_blk_last = r_out_blk_last;
   assign out_valid    = r_out_valid;
   assign err          = r_err;

endmodule

// File: tb/tb_rle_decode_row.sv
// Directed bench for rle_decode_row: vector table plus backpressure,
// zero-count, latency and mid-block reset sequences.
module tb_rle_decode_row;

   logic        clk = 1'b0;
   logic        reset;
   logic [95:0] in_word;
   logic [3:0]  in_count;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_row;
   logic [2:0]  out_row_idx;
   logic        out_blk_last;
   logic        out_valid;
   logic        out_ready;
   logic        err;

   always #5 clk = ~clk;

   rle_decode_row dut (
      .clk          (clk),
      .reset        (reset),
      .in_word      (in_word),
      .in_count     (in_count),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_row      (out_row),
      .out_row_idx  (out_row_idx),
      .out_blk_last (out_blk_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .err          (err)
   );

   typedef struct packed {
      logic [95:0]       word;
      logic [3:0]        cnt;
      int                nrows;
      logic [15:0][63:0] rows;
      logic              err;
   } vec_t;

   vec_t        vecs [6];
   logic [63:0] q_row  [$];
   logic [2:0]  q_idx  [$];
   logic        q_last [$];
   int          n_checks = 0;
   int          n_errors = 0;

   // Record every row handed over (handshake completes at the next rising edge).
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         q_row.push_back(out_row);
         q_idx.push_back(out_row_idx);
         q_last.push_back(out_blk_last);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      q_row.delete();
      q_idx.delete();
      q_last.delete();
   endtask

   task automatic send_word(input logic [95:0] w, input logic [3:0] c);
      logic ok;
      int   t;
      in_word  = w;
      in_count = c;
      in_valid = 1'b1;
      ok = 1'b0;
      t  = 0;
      while (!ok && t < 500) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_word: in_ready got 0 expected 1 within 500 cycles");
      end
   endtask

   task automatic wait_rows(input int n);
      int t;
      t = 0;
      while (q_row.size() < n && t < 1000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 1000) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_rows: got %0d rows expected %0d before timeout", q_row.size(), n);
      end
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic check_rows(input string tag, input vec_t v);
      chk({tag, "_nrows"}, 64'(q_row.size()), 64'(v.nrows));
      for (int i = 0; i < v.nrows; i++) begin
         if (i < q_row.size()) begin
            chk($sformatf("%s_row%0d", tag, i), q_row[i], v.rows[i]);
            chk($sformatf("%s_idx%0d", tag, i), 64'(q_idx[i]), 64'(i % 8));
            chk($sformatf("%s_last%0d", tag, i), 64'(q_last[i]), 64'((i % 8) == 7));
         end
      end
   endtask

   initial begin
      int lo;
      int t;
      logic stable;

      // Vector table: word, count, expected rows (row i at rows[i]), expected err.
      for (int i = 0; i < 6; i++) vecs[i] = '0;
      vecs[0].word = {12'h042, 12'h004, 12'h20D, 12'h40C, 12'h103, 12'h001, 12'h002, 12'h000};
      vecs[0].cnt = 4'd8; vecs[0].nrows = 8;
      vecs[0].rows[0] = 64'h4204_0000_0D00_0000;
      vecs[0].rows[1] = 64'h000C_0003_0102_0000;
      vecs[1].word = {12'h000, 84'h0};
      vecs[1].cnt = 4'd1; vecs[1].nrows = 8;
      // Exactly 64 zeros close the block; 007 opens a new one.
      vecs[2].word = {12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'h007, 12'h000, 24'h0};
      vecs[2].cnt = 4'd6; vecs[2].nrows = 16;
      vecs[2].rows[8] = 64'h0700_0000_0000_0000;
      // F09 starts at index 63 and overruns; 005 opens a new block.
      vecs[3].word = {12'hF00, 12'hF00, 12'hF00, 12'hE00, 12'hF09, 12'h005, 12'h000, 12'h0};
      vecs[3].cnt = 4'd7; vecs[3].nrows = 16; vecs[3].err = 1'b1;
      vecs[3].rows[8] = 64'h0500_0000_0000_0000;
      // Level lands exactly on index 63.
      vecs[4].word = {12'hF00, 12'hF00, 12'hF00, 12'hE00, 12'h007, 36'h0};
      vecs[4].cnt = 4'd5; vecs[4].nrows = 8;
      vecs[4].rows[7] = 64'h0000_0000_0000_0007;
      vecs[5].word = {12'h3FF, 12'h080, 12'h000, 60'h0};
      vecs[5].cnt = 4'd3; vecs[5].nrows = 8;
      vecs[5].rows[0] = 64'h0000_00FF_8000_0000;

      reset = 1'b1; in_valid = 1'b0; in_word = '0; in_count = '0; out_ready = 1'b1;
      do_reset();
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_row", out_row, 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      @(posedge clk); #1;

      for (int v = 0; v < 6; v++) begin
         do_reset();
         out_ready = 1'b1;
         send_word(vecs[v].word, vecs[v].cnt);
         wait_rows(vecs[v].nrows);
         check_rows($sformatf("vec%0d", v), vecs[v]);
         chk($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].err));
         chk($sformatf("vec%0d_in_ready", v), 64'(in_ready), 64'd1);
         $display("vec%0d: word=%h count=%0d rows=%0d err=%0b", v, vecs[v].word, vecs[v].cnt, q_row.size(), err);
      end

      // EOB-only word occupies the buffer for exactly 64 coefficient cycles.
      do_reset();
      send_word(vecs[1].word, vecs[1].cnt);
      lo = 0;
      while (lo < 200) begin
         @(negedge clk);
         if (in_ready) break;
         lo++;
      end
      chk("eob_busy_cycles", 64'(lo), 64'd64);
      $display("eob latency: in_ready low for %0d cycles", lo);
      @(posedge clk); #1;

      // Backpressure: hold row 0 for 20 cycles, then release.
      do_reset();
      out_ready = 1'b0;
      send_word(vecs[0].word, vecs[0].cnt);
      t = 0;
      while (t < 200) begin
         @(negedge clk);
         if (out_valid) break;
         t++;
      end
      chk("bp_first_valid", 64'(out_valid), 64'd1);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_row !== vecs[0].rows[0] || out_valid !== 1'b1 || out_row_idx !== 3'd0) stable = 1'b0;
      end
      chk("bp_row0_held", 64'(stable), 64'd1);
      chk("bp_stalled_busy", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_rows(8);
      check_rows("bp", vecs[0]);
      $display("backpressure: rows=%0d after release", q_row.size());

      // Zero-count word is dropped; then a split word continues mid-row.
      do_reset();
      send_word(96'hFFF_FFF_FFF_FFF_FFF_FFF_FFF_FFF, 4'd0);
      @(negedge clk);
      chk("cnt0_in_ready", 64'(in_ready), 64'd1);
      repeat (20) @(posedge clk);
      #1;
      chk("cnt0_no_rows", 64'(q_row.size()), 64'd0);
      send_word({12'h042, 12'h004, 12'h20D, 60'h0}, 4'd3);
      send_word({12'h40C, 12'h103, 12'h001, 12'h002, 12'h000, 36'h0}, 4'd5);
      wait_rows(8);
      check_rows("split", vecs[0]);
      $display("split words: rows=%0d", q_row.size());

      // Reset mid-block (block 2, after row 2) clears everything incl. sticky err.
      do_reset();
      send_word(vecs[3].word, vecs[3].cnt);
      t = 0;
      while (q_row.size() < 11 && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      chk("mid_err_before", 64'(err), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_in_ready", 64'(in_ready), 64'd1);
      chk("mid_out_valid", 64'(out_valid), 64'd0);
      chk("mid_out_row", out_row, 64'd0);
      chk("mid_row_idx", 64'(out_row_idx), 64'd0);
      chk("mid_blk_last", 64'(out_blk_last), 64'd0);
      chk("mid_err", 64'(err), 64'd0);
      do_reset();
      send_word(vecs[0].word, vecs[0].cnt);
      wait_rows(8);
      check_rows("post_rst", vecs[0]);
      $display("reset mid-block: rows after reset=%0d", q_row.size());

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
